// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues one memory read per PC strobe and queues the
// returned word with its PC for the decoder, with flush on PC redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchPulse,
    input  logic [31:0] pc,
    input  logic        pcChange,
    output logic        available,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic        instValid,
    output logic [31:0] instData,
    output logic [31:0] instPc,
    input  logic        decodeReady
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pcs_q  [DEPTH];

    logic push;
    logic pop;
    logic accept;

    assign available = (state_q == S_IDLE) && (count_q < FULL) && !pcChange;
    assign accept    = fetchPulse && available;
    assign memReq    = (state_q != S_IDLE);
    assign memAddr   = {addr_q[31:2], 2'b00};
    assign instValid = (count_q != '0);
    // Empty FIFO presents zeros so stale entries never leak after a flush.
    assign instData  = instValid ? data_q[rd_ptr_q] : '0;
    assign instPc    = instValid ? pcs_q[rd_ptr_q]  : '0;
    assign push      = (state_q == S_WAIT) && memAck && !pcChange;
    assign pop       = instValid && decodeReady && !pcChange;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = pc;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memAck) begin
                    state_d = S_IDLE;
                end else if (pcChange) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (memAck) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pcChange) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            data_q[wr_ptr_q] <= memData;
            pcs_q[wr_ptr_q]  <= addr_q;
        end
    end
endmodule
